// File: rtl/ctrl_rx_fifo_pkg.sv
// Shared constants for the receive byte FIFO between the serial receiver and the control unit.
// Optional build macro: CTRL_RX_FIFO_STATS_EN (adds the saturating drop counter).
package ctrl_rx_fifo_pkg;

  // Buffer size shared by the control unit and the FIFO top level.
  localparam int CTRL_RX_FIFO_DEPTH = 16;
  localparam int DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] val);
    return (val == {DROP_W{1'b1}}) ? val : val + DROP_W'(1);
  endfunction

endpackage

// File: rtl/ctrl_rx_fifo_if.sv
// Receive FIFO bundle: receiver push side, control-unit pop side and status.
// Optional build macro: CTRL_RX_FIFO_STATS_EN (adds drop_count).
interface ctrl_rx_fifo_if
  import ctrl_rx_fifo_pkg::*;
#(
  parameter int DEPTH   = CTRL_RX_FIFO_DEPTH,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
);
  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               flush;
  logic [7:0]         in_byte;
  logic               in_ready;
  logic               next;
  logic [LEVEL_W-1:0] level;
  logic               full;
  logic               overflow;
  logic               underflow;
`ifdef CTRL_RX_FIFO_STATS_EN
  logic [DROP_W-1:0]  drop_count;
`endif

  modport master (
    output rx_byte, rx_valid, flush, next,
    input  in_byte, in_ready, level, full, overflow, underflow
`ifdef CTRL_RX_FIFO_STATS_EN
    , input drop_count
`endif
  );

  modport slave (
    input  rx_byte, rx_valid, flush, next,
    output in_byte, in_ready, level, full, overflow, underflow
`ifdef CTRL_RX_FIFO_STATS_EN
    , output drop_count
`endif
  );

endinterface

// File: rtl/ctrl_rx_fifo_mem.sv
// Simple dual-port byte RAM: one synchronous write port, one asynchronous read port.
// Written to map onto distributed RAM; no reset on the array.
module ctrl_rx_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_rx_fifo.sv
// Show-ahead receive byte FIFO with registered head, level/full flags and overflow/underflow pulses.
// Optional build macro: CTRL_RX_FIFO_STATS_EN (saturating drop_count, cleared only by reset).
module ctrl_rx_fifo
  import ctrl_rx_fifo_pkg::*;
#(
  parameter int DEPTH   = CTRL_RX_FIFO_DEPTH,
  localparam int LEVEL_W = $clog2(DEPTH) + 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         reset,
  ctrl_rx_fifo_if.slave bus
);
  logic [LEVEL_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt;
  logic [LEVEL_W-1:0] level_q;
  logic [7:0]         in_byte_q, mem_rdata, head_nxt;
  logic               in_ready_q, full_q, overflow_q, underflow_q;
  logic               push, pop, clr, ovf_evt;

  assign clr     = reset || bus.flush;
  assign pop     = bus.next && in_ready_q;
  assign push    = bus.rx_valid && (!full_q || pop);
  assign ovf_evt = bus.rx_valid && full_q && !pop;

  assign wr_nxt    = push ? wr_ptr + LEVEL_W'(1) : wr_ptr;
  assign rd_nxt    = pop  ? rd_ptr + LEVEL_W'(1) : rd_ptr;
  assign level_nxt = wr_nxt - rd_nxt;

  // The head is read at the post-update read pointer; when that slot is the one
  // being written this cycle the RAM does not hold it yet, so take rx_byte.
  assign head_nxt = (push && (rd_nxt == wr_ptr)) ? bus.rx_byte : mem_rdata;

  ctrl_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push && !clr),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.rx_byte),
    .raddr (rd_nxt[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      in_byte_q   <= 8'h00;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      level_q     <= level_nxt;
      full_q      <= (level_nxt == LEVEL_W'(DEPTH));
      in_ready_q  <= (level_nxt != '0);
      in_byte_q   <= head_nxt;
      overflow_q  <= ovf_evt;
      underflow_q <= bus.next && !in_ready_q;
    end
  end

  assign bus.in_byte   = in_byte_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.level     = level_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef CTRL_RX_FIFO_STATS_EN
  logic [DROP_W-1:0] drop_count_q;

  // A byte offered during flush is discarded, not counted as dropped.
  always_ff @(posedge clk) begin
    if (reset)                       drop_count_q <= '0;
    else if (!bus.flush && ovf_evt)  drop_count_q <= sat_inc(drop_count_q);
  end

  assign bus.drop_count = drop_count_q;
`endif

endmodule
